// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM (byte write enables, 1-cycle registered read)
//   between the CPU data path and the DDMA memory path of a PE.
//   One requester is granted per cycle. The grant is decided combinationally
//   from the current requests and registered history, so an access is
//   accepted in the same cycle it is requested.
//
// Ports
//   clock, reset                   rising-edge clock, async active-low reset
//   cpu_req/addr/wb/wdata          CPU request (wb==0 means read)
//   cpu_stall                      CPU must hold its request this cycle
//   cpu_rdata/cpu_rvalid           CPU read return, one cycle after grant
//   dma_req/lock/addr/wb/wdata     DDMA request; lock asks to keep the port
//   dma_gnt                        DDMA access accepted this cycle
//   dma_rdata/dma_rvalid           DDMA read return, one cycle after grant
//   mem_enable/addr/wb/data_in     RAM command port
//   mem_data_out                   RAM read data, valid the cycle after a read
module ram_port_arbiter #(
  parameter int MEMORY_WIDTH  = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int DMA_BURST_MAX = 8,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [3:0]              cpu_wb,
  input  logic [MEMORY_WIDTH-1:0] cpu_wdata,
  output logic                    cpu_stall,
  output logic [MEMORY_WIDTH-1:0] cpu_rdata,
  output logic                    cpu_rvalid,
  input  logic                    dma_req,
  input  logic                    dma_lock,
  input  logic [ADDR_WIDTH-1:0]   dma_addr,
  input  logic [3:0]              dma_wb,
  input  logic [MEMORY_WIDTH-1:0] dma_wdata,
  output logic                    dma_gnt,
  output logic [MEMORY_WIDTH-1:0] dma_rdata,
  output logic                    dma_rvalid,
  output logic                    mem_enable,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [3:0]              mem_wb,
  output logic [MEMORY_WIDTH-1:0] mem_data_in,
  input  logic [MEMORY_WIDTH-1:0] mem_data_out
);

  localparam int BURST_W  = $clog2(DMA_BURST_MAX + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [BURST_W-1:0]  BURST_MAX_C  = BURST_W'(DMA_BURST_MAX);
  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_DMA  = 2'd2
  } owner_t;

  logic [BURST_W-1:0]  burst_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                last_dma;
  owner_t              rd_owner;

  logic dma_keep;
  logic dma_starved;
  logic cpu_grant;
  logic dma_grant;

  // Grant decision. Requests are qualified by reset so that nothing is
  // granted (and the CPU is not stalled) while reset is held low.
  always_comb begin
    dma_keep    = last_dma && dma_lock && (burst_cnt < BURST_MAX_C);
    dma_starved = (starve_cnt == STARVE_MAX_C);
    cpu_grant   = 1'b0;
    dma_grant   = 1'b0;
    if (reset) begin
      if (dma_req && (!cpu_req || dma_keep || dma_starved)) begin
        dma_grant = 1'b1;
      end else if (cpu_req) begin
        cpu_grant = 1'b1;
      end
    end
  end

  // RAM command mux; idle cycles drive an all-zero command.
  always_comb begin
    mem_enable  = 1'b0;
    mem_addr    = '0;
    mem_wb      = '0;
    mem_data_in = '0;
    if (cpu_grant) begin
      mem_enable  = 1'b1;
      mem_addr    = cpu_addr;
      mem_wb      = cpu_wb;
      mem_data_in = cpu_wdata;
    end else if (dma_grant) begin
      mem_enable  = 1'b1;
      mem_addr    = dma_addr;
      mem_wb      = dma_wb;
      mem_data_in = dma_wdata;
    end
  end

  assign cpu_stall = reset && cpu_req && !cpu_grant;
  assign dma_gnt   = dma_grant;

  // History registers: burst length, starvation age, and the owner of the
  // read whose data returns next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burst_cnt  <= '0;
      starve_cnt <= '0;
      last_dma   <= 1'b0;
      rd_owner   <= OWNER_NONE;
    end else begin
      if (dma_grant) begin
        if (!last_dma) begin
          burst_cnt <= BURST_W'(1);
        end else if (burst_cnt < BURST_MAX_C) begin
          burst_cnt <= burst_cnt + BURST_W'(1);
        end
        starve_cnt <= '0;
      end else begin
        burst_cnt <= '0;
        if (!dma_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt < STARVE_MAX_C) begin
          starve_cnt <= starve_cnt + STARVE_W'(1);
        end
      end

      last_dma <= dma_grant;

      if (cpu_grant && (cpu_wb == 4'd0)) begin
        rd_owner <= OWNER_CPU;
      end else if (dma_grant && (dma_wb == 4'd0)) begin
        rd_owner <= OWNER_DMA;
      end else begin
        rd_owner <= OWNER_NONE;
      end
    end
  end

  // Both requesters see the raw RAM output; the valid bits say whose it is.
  assign cpu_rdata  = mem_data_out;
  assign dma_rdata  = mem_data_out;
  assign cpu_rvalid = (rd_owner == OWNER_CPU);
  assign dma_rvalid = (rd_owner == OWNER_DMA);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: behavioural RAM plus a reference model of
// the arbitration rules, directed scenarios and a randomized run.
module tb_ram_port_arbiter;

  localparam int MW   = 32;
  localparam int AW   = 16;
  localparam int BMAX = 8;
  localparam int SLIM = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [3:0]    cpu_wb = '0;
  logic [MW-1:0] cpu_wdata = '0;
  logic          cpu_stall;
  logic [MW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          dma_req = 1'b0;
  logic          dma_lock = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [3:0]    dma_wb = '0;
  logic [MW-1:0] dma_wdata = '0;
  logic          dma_gnt;
  logic [MW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          mem_enable;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wb;
  logic [MW-1:0] mem_data_in;
  logic [MW-1:0] mem_data_out;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(
    .MEMORY_WIDTH (MW),
    .ADDR_WIDTH   (AW),
    .DMA_BURST_MAX(BMAX),
    .STARVE_LIMIT (SLIM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_wb      (cpu_wb),
    .cpu_wdata   (cpu_wdata),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .dma_req     (dma_req),
    .dma_lock    (dma_lock),
    .dma_addr    (dma_addr),
    .dma_wb      (dma_wb),
    .dma_wdata   (dma_wdata),
    .dma_gnt     (dma_gnt),
    .dma_rdata   (dma_rdata),
    .dma_rvalid  (dma_rvalid),
    .mem_enable  (mem_enable),
    .mem_addr    (mem_addr),
    .mem_wb      (mem_wb),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Behavioural single-port RAM with a preload side door.
  logic [MW-1:0] ram [0:65535];
  logic [MW-1:0] ram_q = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [MW-1:0] pl_data = '0;

  always @(posedge clock) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_enable) begin
      if (mem_wb == 4'd0) begin
        ram_q <= ram[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wb[b]) ram[mem_addr][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
      end
    end
  end
  assign mem_data_out = ram_q;

  // Reference model: counts of consecutive DMA wins and denials, the owner of
  // the pending read (0 none, 1 cpu, 2 dma) and a shadow copy of memory.
  logic [MW-1:0] ref_mem [0:65535];
  int            dma_run = 0;
  int            denied = 0;
  int            pend = 0;
  logic [MW-1:0] pend_data = '0;

  function automatic int exp_winner();
    if (!reset) return 0;
    if (cpu_req && !dma_req) return 1;
    if (dma_req && !cpu_req) return 2;
    if (!cpu_req) return 0;
    if ((dma_run > 0 && dma_lock && dma_run < BMAX) || denied >= SLIM) return 2;
    return 1;
  endfunction

  task automatic write_ref(input logic [AW-1:0] a, input logic [3:0] wb, input logic [MW-1:0] d);
    for (int b = 0; b < 4; b++) begin
      if (wb[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_step();
    int w;
    w = exp_winner();
    if (!reset) begin
      dma_run = 0;
      denied  = 0;
      pend    = 0;
      return;
    end
    pend = 0;
    if (w == 1) begin
      if (cpu_wb == 4'd0) begin pend = 1; pend_data = ref_mem[cpu_addr]; end
      else write_ref(cpu_addr, cpu_wb, cpu_wdata);
    end else if (w == 2) begin
      if (dma_wb == 4'd0) begin pend = 2; pend_data = ref_mem[dma_addr]; end
      else write_ref(dma_addr, dma_wb, dma_wdata);
    end
    dma_run = (w == 2) ? ((dma_run < BMAX) ? dma_run + 1 : BMAX) : 0;
    denied  = (dma_req && w != 2) ? ((denied < SLIM) ? denied + 1 : SLIM) : 0;
  endtask

  task automatic drive(input logic c, input logic [AW-1:0] ca, input logic [3:0] cw,
                       input logic [MW-1:0] cd, input logic d, input logic l,
                       input logic [AW-1:0] da, input logic [3:0] dw, input logic [MW-1:0] dd);
    cpu_req = c;  cpu_addr = ca; cpu_wb = cw; cpu_wdata = cd;
    dma_req = d;  dma_lock = l;  dma_addr = da; dma_wb = dw; dma_wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock edge: update the model with the inputs seen at the edge.
  task automatic advance();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [MW-1:0] d);
    idle();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    advance();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 16'h0004, 4'h0, '0, 1'b1, 1'b1, 16'h0008, 4'h0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL reset_dma_gnt got=%0b exp=0", dma_gnt); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_cpu_stall got=%0b exp=0", cpu_stall); end
      checks++; if (mem_enable !== 1'b0 || mem_wb !== 4'h0) begin failures++; $display("FAIL reset_mem got=%0b/%h exp=0/0", mem_enable, mem_wb); end
      checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b%0b exp=00", cpu_rvalid, dma_rvalid); end
      advance();
    end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("FAIL release_cpu_first got gnt=%0b stall=%0b exp=0/0", dma_gnt, cpu_stall); end
    checks++; if (mem_enable !== 1'b1 || mem_addr !== 16'h0004) begin failures++; $display("FAIL release_mem got en=%0b addr=%h exp=1/0004", mem_enable, mem_addr); end
    advance();
    idle();
    advance();
  endtask

  task automatic test_cpu_read();
    preload(16'h0010, 32'hDEADBEEF);
    drive(1'b1, 16'h0010, 4'h0, '0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clock);
    checks++; if (mem_addr !== 16'h0010 || mem_wb !== 4'h0 || mem_enable !== 1'b1) begin failures++; $display("FAIL cpu_read_cmd got addr=%h wb=%h en=%0b exp=0010/0/1", mem_addr, mem_wb, mem_enable); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cpu_read_stall got=%0b exp=0", cpu_stall); end
    advance();
    idle();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_read_data got v=%0b d=%h exp=1/deadbeef", cpu_rvalid, cpu_rdata); end
    checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL cpu_read_dma_rvalid got=%0b exp=0", dma_rvalid); end
    advance();
  endtask

  task automatic test_starve();
    idle();
    advance();
    drive(1'b1, 16'h0010, 4'h0, '0, 1'b1, 1'b0, 16'h0011, 4'h0, '0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      checks++; if (dma_gnt !== ((i % 5) == 4)) begin failures++; $display("FAIL starve_gnt cycle=%0d got=%0b exp=%0b", i, dma_gnt, (i % 5) == 4); end
      checks++; if (cpu_stall !== ((i % 5) == 4)) begin failures++; $display("FAIL starve_stall cycle=%0d got=%0b exp=%0b", i, cpu_stall, (i % 5) == 4); end
      advance();
      checks++; if (cpu_rvalid !== (pend == 1) || dma_rvalid !== (pend == 2)) begin failures++; $display("FAIL starve_rvalid cycle=%0d got=%0b%0b exp_owner=%0d", i, cpu_rvalid, dma_rvalid, pend); end
    end
    idle();
    advance();
  endtask

  task automatic test_burst();
    int stalls;
    stalls = 0;
    idle();
    advance();
    drive(1'b0, 16'h0020, 4'h0, '0, 1'b1, 1'b1, 16'h0030, 4'h0, '0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) cpu_req = 1'b1;
      @(negedge clock);
      checks++; if (dma_gnt !== (k <= 8)) begin failures++; $display("FAIL burst_gnt cycle=%0d got=%0b exp=%0b", k, dma_gnt, k <= 8); end
      if (cpu_stall === 1'b1) stalls++;
      if (k == 9) begin
        checks++; if (mem_addr !== 16'h0020 || mem_enable !== 1'b1) begin failures++; $display("FAIL burst_cpu_after got addr=%h exp=0020", mem_addr); end
      end
      advance();
    end
    checks++; if (stalls !== 7) begin failures++; $display("FAIL burst_stall_count got=%0d exp=7", stalls); end
    idle();
    advance();
  endtask

  task automatic test_back_to_back();
    preload(16'h0100, 32'h11111111);
    preload(16'h0200, 32'h22222222);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 16'h0100, 4'h0, '0);
    advance();
    drive(1'b1, 16'h0200, 4'h0, '0, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== 32'h11111111) begin failures++; $display("FAIL b2b_dma got v=%0b%0b d=%h exp=01/11111111", cpu_rvalid, dma_rvalid, dma_rdata); end
    advance();
    idle();
    checks++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || cpu_rdata !== 32'h22222222) begin failures++; $display("FAIL b2b_cpu got v=%0b%0b d=%h exp=10/22222222", cpu_rvalid, dma_rvalid, cpu_rdata); end
    advance();
    checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b%0b exp=00", cpu_rvalid, dma_rvalid); end
  endtask

  task automatic test_write();
    drive(1'b1, 16'h0040, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clock);
    checks++; if (mem_wb !== 4'hF || mem_data_in !== 32'hA5A5A5A5) begin failures++; $display("FAIL write_cmd got wb=%h d=%h exp=f/a5a5a5a5", mem_wb, mem_data_in); end
    advance();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 16'h0040, 4'h3, 32'h1234BEEF);
    checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin failures++; $display("FAIL write_no_rvalid got=%0b%0b exp=00", cpu_rvalid, dma_rvalid); end
    advance();
    drive(1'b1, 16'h0040, 4'h0, '0, 1'b0, 1'b0, '0, '0, '0);
    advance();
    idle();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5BEEF) begin failures++; $display("FAIL write_readback got v=%0b d=%h exp=1/a5a5beef", cpu_rvalid, cpu_rdata); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0100, 4'h0, '0);
    advance();
    checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL midreset_pre got=%0b exp=1", dma_rvalid); end
    reset = 1'b0;
    #1;
    checks++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin failures++; $display("FAIL midreset_drop got=%0b%0b exp=00", cpu_rvalid, dma_rvalid); end
    checks++; if (dma_gnt !== 1'b0 || mem_enable !== 1'b0) begin failures++; $display("FAIL midreset_gnt got=%0b/%0b exp=0/0", dma_gnt, mem_enable); end
    advance();
    reset = 1'b1;
    drive(1'b1, 16'h0200, 4'h0, '0, 1'b1, 1'b1, 16'h0100, 4'h0, '0);
    @(negedge clock);
    checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("FAIL midreset_burst_restart got gnt=%0b stall=%0b exp=0/0", dma_gnt, cpu_stall); end
    advance();
    idle();
    advance();
  endtask

  task automatic test_random();
    int w;
    logic [AW-1:0] ea;
    logic [3:0]    ew;
    logic [MW-1:0] ed;
    for (int a = 0; a < 16; a++) preload(AW'(a), $urandom);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
            $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            AW'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
            $urandom);
      @(negedge clock);
      w = exp_winner();
      ea = (w == 1) ? cpu_addr  : (w == 2) ? dma_addr  : '0;
      ew = (w == 1) ? cpu_wb    : (w == 2) ? dma_wb    : '0;
      ed = (w == 1) ? cpu_wdata : (w == 2) ? dma_wdata : '0;
      checks++; if (dma_gnt !== (w == 2) || cpu_stall !== (cpu_req && w != 1)) begin failures++; $display("FAIL rand_grant i=%0d got gnt=%0b stall=%0b exp_winner=%0d", i, dma_gnt, cpu_stall, w); end
      checks++; if (mem_enable !== (w != 0) || mem_addr !== ea || mem_wb !== ew || mem_data_in !== ed) begin failures++; $display("FAIL rand_mem i=%0d got en=%0b a=%h wb=%h d=%h exp a=%h wb=%h d=%h", i, mem_enable, mem_addr, mem_wb, mem_data_in, ea, ew, ed); end
      advance();
      checks++; if (cpu_rvalid !== (pend == 1) || dma_rvalid !== (pend == 2)) begin failures++; $display("FAIL rand_rvalid i=%0d got=%0b%0b exp_owner=%0d", i, cpu_rvalid, dma_rvalid, pend); end
      if (pend != 0) begin
        checks++; if (cpu_rdata !== pend_data || dma_rdata !== pend_data) begin failures++; $display("FAIL rand_rdata i=%0d got=%h/%h exp=%h", i, cpu_rdata, dma_rdata, pend_data); end
      end
    end
    idle();
    advance();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ref_mem[a] = '0;
    test_reset();
    test_cpu_read();
    test_starve();
    test_burst();
    test_back_to_back();
    test_write();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port RAM port (byte write enables, 1-cycle registered read) between the CPU data path and the DDMA memory path inside a PE.
- Grants one requester per cycle.
- Stalls the CPU while the DMA owns the port.
- Steers read data back to the requester that issued the read.
- Bounds DMA bursts and DMA starvation with counters.

Parameters:
- MEMORY_WIDTH, 32, data width of all data buses.
- ADDR_WIDTH, 16, RAM word/byte address width (64 KiB window).
- DMA_BURST_MAX, 8, maximum consecutive DMA grants under dma_lock while the CPU is requesting.
- STARVE_LIMIT, 4, consecutive denied DMA cycles that force one DMA grant over the CPU.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests the RAM this cycle.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wb  in  4  CPU byte write enables; 0 = read.
- cpu_wdata  in  MEMORY_WIDTH  CPU write data.
- cpu_stall  out  1  CPU must hold its request.
- cpu_rdata  out  MEMORY_WIDTH  read data to CPU.
- cpu_rvalid  out  1  cpu_rdata valid.
- dma_req  in  1  DDMA requests the RAM.
- dma_lock  in  1  DDMA asks to keep the port for the next beat.
- dma_addr  in  ADDR_WIDTH  DDMA address.
- dma_wb  in  4  DDMA byte write enables; 0 = read.
- dma_wdata  in  MEMORY_WIDTH  DDMA write data.
- dma_gnt  out  1  DDMA access accepted this cycle.
- dma_rdata  out  MEMORY_WIDTH  read data to DDMA.
- dma_rvalid  out  1  dma_rdata valid.
- mem_enable  out  1  RAM enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wb  out  4  RAM byte write enables.
- mem_data_in  out  MEMORY_WIDTH  RAM write data.
- mem_data_out  in  MEMORY_WIDTH  RAM read data, valid the cycle after a read.

Behaviour:
- State registers:
  - burst_cnt: consecutive DMA grants, saturating at DMA_BURST_MAX.
  - starve_cnt: consecutive cycles with dma_req && !dma_gnt, saturating at STARVE_LIMIT.
  - last_dma: DMA was granted the previous cycle.
  - rd_owner: NONE/CPU/DMA.
- Grant decision is combinational from the current requests and registered state, so a grant is given the same cycle as the request.
  - No request: no grant; mem_enable=0, mem_wb=0, mem_addr=0, mem_data_in=0.
  - Only cpu_req: CPU granted.
  - Only dma_req: DMA granted, regardless of counters.
  - Both requesting, DMA wins if either holds: (a) last_dma && dma_lock && burst_cnt < DMA_BURST_MAX; (b) starve_cnt == STARVE_LIMIT. Otherwise CPU wins.
- Granted requester's addr/wb/wdata drive mem_*; mem_enable=1. Data passes unmodified (no byte swap).
- cpu_stall = cpu_req && !cpu_grant. dma_gnt = DMA grant.
- burst_cnt on DMA grant: last_dma ? min(burst_cnt+1, DMA_BURST_MAX) : 1. On no DMA grant: 0.
- starve_cnt: cleared on DMA grant or when !dma_req; incremented, saturating, when dma_req && !dma_gnt.
- rd_owner next value: CPU if CPU granted with wb==0; DMA if DMA granted with wb==0; NONE otherwise (writes and idle cycles).
- Read return, 1 cycle later:
  - cpu_rvalid = (rd_owner==CPU); dma_rvalid = (rd_owner==DMA).
  - cpu_rdata and dma_rdata both equal mem_data_out; the valid bits qualify them.
  - Read latency is exactly 1 cycle after the grant cycle.
- Back-to-back reads from alternating owners are legal: each return goes to the owner recorded at its grant.
- While reset=0, and at the first edge after release:
  - all counters 0, last_dma=0, rd_owner=NONE.
  - dma_gnt=0, cpu_stall=0, cpu_rvalid=0, dma_rvalid=0, mem_enable=0, mem_wb=0.
  - Requests are ignored while reset is low.
- Reset asserted mid-operation: rvalid for a read granted in the previous cycle is dropped (rd_owner cleared asynchronously); a DMA burst in progress restarts with burst_cnt=0.
- dma_lock without dma_req has no effect. dma_lock is ignored once burst_cnt reaches DMA_BURST_MAX; the CPU then wins the next contended cycle.

Test Plan:
- Reset low 3 cycles with cpu_req=dma_req=1 -> dma_gnt=0, cpu_stall=0, mem_enable=0, no rvalid. Release -> CPU granted in the first cycle.
- CPU read addr 0x0010 alone, RAM holds 0xDEADBEEF -> mem_addr=0x0010, mem_wb=0, cpu_stall=0. Next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dma_rvalid=0.
- Both requesting continuously, dma_lock=0, STARVE_LIMIT=4 -> pattern CPU,CPU,CPU,CPU,DMA repeating. cpu_stall=1 only on the DMA cycle.
- DMA starts alone with dma_lock=1, then CPU requests from cycle 2 -> DMA holds 8 consecutive grants (burst_cnt 1..8), then CPU granted. cpu_stall high for 7 cycles.
- Alternating grants: DMA read 0x0100 (data 0x11111111) then CPU read 0x0200 (data 0x22222222) in consecutive cycles -> dma_rvalid with 0x11111111, then cpu_rvalid with 0x22222222, never both in the same cycle.
- CPU write wb=0xF addr 0x0040 data 0xA5A5A5A5 -> mem_wb=0xF, no rvalid next cycle. A following CPU read of 0x0040 returns 0xA5A5A5A5.
